// File: rtl/warp_sched_pkg.sv
// Shared types and default sizing for the round-robin warp scheduler.
package warp_sched_pkg;

    localparam int DEFAULT_NUM_WARPS = 4;
    localparam int DEFAULT_PC_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } warp_state_e;

endpackage

// File: rtl/warp_ctx.sv
// Per-warp context: lifecycle state and program counter.
// Priority among the per-warp controls: reset > start (non-active) > done > branch > issue.
module warp_ctx
    import warp_sched_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic                issue,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                done,
    output warp_state_e         state,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (done) begin
                        state <= DONE;
                    end else if (branch) begin
                        pc <= br_target;
                    end else if (issue) begin
                        pc <= pc + PC_WIDTH'(1);
                    end
                end
                default: begin
                    // Idle and finished warps only react to a launch.
                    if (start) begin
                        state <= ACTIVE;
                        pc    <= start_pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rr_warp_scheduler.sv
// Round-robin warp scheduler: picks the next ready warp after the last one issued.
// Define WARP_SCHED_PERF_EN to add saturating issue_count/stall_count outputs.
module rr_warp_scheduler
    import warp_sched_pkg::*;
#(
    parameter int  NUM_WARPS = DEFAULT_NUM_WARPS,
    parameter int  PC_WIDTH  = DEFAULT_PC_WIDTH,
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic [NUM_WARPS-1:0] warp_ready,
    input  logic                 fetch_ready,
    output logic                 issue_valid,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [WID_W-1:0]     warp_num,
    input  logic                 br_valid,
    input  logic [WID_W-1:0]     br_warp,
    input  logic [PC_WIDTH-1:0]  br_target,
    input  logic                 done_valid,
    input  logic [WID_W-1:0]     done_warp,
    output logic [NUM_WARPS-1:0] active_mask,
    output logic                 all_done
`ifdef WARP_SCHED_PERF_EN
    ,output logic [31:0]         issue_count
    ,output logic [31:0]         stall_count
`endif
);

    warp_state_e         ctx_state [NUM_WARPS];
    logic [PC_WIDTH-1:0] ctx_pc    [NUM_WARPS];
    logic [NUM_WARPS-1:0] done_mask;
    logic [NUM_WARPS-1:0] eligible;
    logic [WID_W-1:0]     last_issued;
    logic [WID_W-1:0]     sel;
    logic [WID_W-1:0]     idx;
    logic                 found;
    logic                 issue_fire;

    for (genvar i = 0; i < NUM_WARPS; i++) begin : g_ctx
        warp_ctx #(.PC_WIDTH(PC_WIDTH)) u_ctx (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .start_pc  (start_pc),
            .issue     (issue_fire && (sel == WID_W'(i))),
            .branch    (br_valid && (br_warp == WID_W'(i))),
            .br_target (br_target),
            .done      (done_valid && (done_warp == WID_W'(i))),
            .state     (ctx_state[i]),
            .pc        (ctx_pc[i])
        );
        assign active_mask[i] = (ctx_state[i] == ACTIVE);
        assign done_mask[i]   = (ctx_state[i] == DONE);
    end

    assign eligible = active_mask & warp_ready;
    assign all_done = &done_mask;

    // Search starts one past the last issued warp; WID_W-bit wrap gives the modulo for free.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx = last_issued + WID_W'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign issue_valid = found;
    assign warp_num    = found ? sel : '0;
    assign pc          = found ? ctx_pc[sel] : '0;
    assign issue_fire  = found && fetch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_issued <= WID_W'(NUM_WARPS - 1);
        end else if (issue_fire) begin
            last_issued <= sel;
        end
    end

`ifdef WARP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue_fire && (issue_count != '1)) begin
                issue_count <= issue_count + 32'd1;
            end
            if ((|active_mask) && !issue_fire && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
